// File: rtl/irq_ctrl_if.sv
// Configuration register bus for irq_ctrl.
// The master drives strobes/data; the slave returns combinational read data.
interface irq_ctrl_if;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;

    modport master (
        output cfg_we,
        output cfg_addr,
        output cfg_wdata,
        input  cfg_rdata
    );

    modport slave (
        input  cfg_we,
        input  cfg_addr,
        input  cfg_wdata,
        output cfg_rdata
    );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronized lines, MASK/EDGE/PEND registers,
// fixed-priority arbitration and a request/service handshake with CP0.
module irq_ctrl #(
    parameter int N_IRQ = 8,
    parameter int IDW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    irq_ctrl_if.slave        bus,
    output logic             ir_out,
    input  logic             ir_ack,
    input  logic             eret_in,
    output logic [IDW-1:0]   irq_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N_IRQ-1:0] sync1_q, sync2_q, sync3_q;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [N_IRQ-1:0] edge_q, edge_d;
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic             ir_out_q, ir_out_d;
    logic [IDW-1:0]   irq_id_q, irq_id_d;

    logic [N_IRQ-1:0] wdata;
    logic [N_IRQ-1:0] elig;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] ack_clr;
    logic [N_IRQ-1:0] clr;
    logic [IDW-1:0]   win_id;
    logic             hit;
    logic             wr_mask, wr_edge, wr_pend;
    logic [31:0]      status;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            sync3_q  <= '0;
            mask_q   <= '0;
            edge_q   <= '0;
            pend_q   <= '0;
            state_q  <= IDLE;
            ir_out_q <= 1'b0;
            irq_id_q <= '0;
        end else begin
            sync1_q  <= irq_in;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            mask_q   <= mask_d;
            edge_q   <= edge_d;
            pend_q   <= pend_d;
            state_q  <= state_d;
            ir_out_q <= ir_out_d;
            irq_id_q <= irq_id_d;
        end
    end

    always_comb begin
        wdata   = bus.cfg_wdata[N_IRQ-1:0];
        wr_mask = bus.cfg_we && (bus.cfg_addr == 2'd0);
        wr_edge = bus.cfg_we && (bus.cfg_addr == 2'd1);
        wr_pend = bus.cfg_we && (bus.cfg_addr == 2'd2);
        elig    = pend_q & mask_q;
        hit     = mask_q[irq_id_q] & pend_q[irq_id_q];
        rise    = sync2_q & ~sync3_q;

        // Scan high to low so the lowest eligible index wins.
        win_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) win_id = IDW'(i);
        end

        state_d  = state_q;
        irq_id_d = irq_id_q;
        ack_clr  = '0;
        unique case (state_q)
            IDLE: begin
                if (|elig) begin
                    state_d  = REQ;
                    irq_id_d = win_id;
                end
            end
            REQ: begin
                if (ir_ack) begin
                    state_d = SERVICE;
                    ack_clr = N_IRQ'(1) << irq_id_q;
                end else if (!hit) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (eret_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ir_out_d = (state_d == REQ);

        // Edge bits: a fresh rising edge beats any clear in the same cycle.
        clr    = (wr_pend ? wdata : '0) | ack_clr;
        pend_d = (edge_q & (rise | (pend_q & ~clr)))
               | (~edge_q & sync2_q);
        mask_d = wr_mask ? wdata : mask_q;
        edge_d = wr_edge ? wdata : edge_q;
    end

    always_comb begin
        status          = '0;
        status[1:0]     = state_q;
        status[IDW+7:8] = irq_id_q;
        unique case (bus.cfg_addr)
            2'd0: bus.cfg_rdata = 32'(mask_q);
            2'd1: bus.cfg_rdata = 32'(edge_q);
            2'd2: bus.cfg_rdata = 32'(pend_q);
            2'd3: bus.cfg_rdata = status;
        endcase
    end

    if (N_IRQ < 32) begin : g_hi
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^bus.cfg_wdata[31:N_IRQ];
    end

    assign ir_out = ir_out_q;
    assign irq_id = irq_id_q;

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have parameter N_IRQ, default 8, giving the number of external interrupt lines (2..32).
REQ-002 The block SHALL have parameter IDW, default 3, giving the width of the interrupt ID, equal to clog2(N_IRQ).
REQ-003 The block SHALL have port clk  input  1  main clock; all state SHALL update on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port irq_in  input  N_IRQ  raw external interrupt lines, asynchronous to clk.
REQ-006 The block SHALL have port cfg_we  input  1  configuration register write strobe.
REQ-007 The block SHALL have port cfg_addr  input  2  register select: 0=MASK, 1=EDGE, 2=PEND, 3=STATUS.
REQ-008 The block SHALL have port cfg_wdata  input  32  write data; bits above N_IRQ-1 ignored.
REQ-009 The block SHALL have port cfg_rdata  output  32  combinational read of the selected register, zero-extended.
REQ-010 The block SHALL have port ir_out  output  1  interrupt request, registered; drives CP0 ir_in.
REQ-011 The block SHALL have port ir_ack  input  1  pulse from CP0 when it takes the interrupt, i.e. jump_en with no ERET.
REQ-012 The block SHALL have port eret_in  input  1  pulse when CP0 executes ERET.
REQ-013 The block SHALL have port irq_id  output  IDW  ID of the interrupt being requested or serviced, registered.

Function
REQ-014 Each irq_in bit SHALL pass a 2-flop synchronizer, then a third flop used for edge detection.
REQ-015 Edge-mode lines (EDGE bit=1) SHALL set their PEND bit on a synchronized rising edge, one cycle after the edge appears at sync stage 2.
REQ-016 Level-mode lines (EDGE bit=0) SHALL have their PEND bit equal the synchronized level, registered, and SHALL not be software-clearable.
REQ-017 A write to PEND SHALL be write-1-to-clear for edge-mode bits, and a hardware set in the same cycle SHALL win over the clear.
REQ-018 A write to MASK or EDGE SHALL take effect on the next clock edge; STATUS SHALL be read-only, with bits [1:0] = state and bits [IDW+7:8] = irq_id.
REQ-019 Eligible SHALL be PEND & MASK, and priority SHALL be fixed with the lowest index highest.
REQ-020 The FSM SHALL have states IDLE=0, REQ=1 and SERVICE=2; encoding 3 is unused and SHALL map to IDLE.
REQ-021 In IDLE with eligible nonzero, the FSM SHALL move to REQ and latch irq_id = highest-priority eligible index.
REQ-022 In REQ, ir_out SHALL be 1, and irq_id SHALL be held; it SHALL not re-arbitrate when a higher-priority line arrives.
REQ-023 In REQ with ir_ack=1, the FSM SHALL move to SERVICE, clear PEND[irq_id] if that line is edge-mode, and drop ir_out next cycle.
REQ-024 In REQ, if MASK[irq_id] is cleared or PEND[irq_id] falls (level line released) without ir_ack, the FSM SHALL return to IDLE and ir_out SHALL fall.
REQ-025 In REQ, ir_ack SHALL win over a simultaneous withdrawal.
REQ-026 In SERVICE, ir_out SHALL be 0; on eret_in the FSM SHALL go to IDLE, and may re-enter REQ on the following cycle.
REQ-027 The block SHALL ignore ir_ack in IDLE and SERVICE, and SHALL ignore eret_in in IDLE and REQ.
REQ-028 ir_out SHALL be registered as (next state == REQ), so that ir_out is high exactly in cycles where the state is REQ.
REQ-029 The block SHALL have a minimum latency of 4 clocks from a rising irq_in at edge 0 to ir_out=1 after edge 4, for an edge-mode line that is unmasked, with the FSM in IDLE.

Reset
REQ-030 While rst=0, the block SHALL hold: sync/edge flops=0, MASK=0, EDGE=0, PEND=0, state=IDLE, ir_out=0, irq_id=0.
REQ-031 Reset asserted mid-operation (REQ or SERVICE) SHALL immediately force ir_out=0 and state=IDLE, and all pending requests SHALL be lost.
REQ-032 After rst rises, the first clock edge SHALL operate normally; no interrupt SHALL be generated until MASK is written.

Verification
REQ-033 The bench SHALL cover: MASK=0x01, EDGE=0x01, pulse irq_in[0] for 1 clk -> ir_out=1 exactly 4 clocks later, irq_id=0, STATUS[1:0]=1.
REQ-034 The bench SHALL cover: from REQ, apply ir_ack -> next cycle ir_out=0, state=SERVICE, PEND[0]=0; then eret_in -> state=IDLE, ir_out stays 0.
REQ-035 The bench SHALL cover: MASK=0xFF, EDGE=0xFF, rise irq_in[5] and irq_in[2] together -> irq_id=2; after ack and eret -> second request with irq_id=5.
REQ-036 The bench SHALL cover: level line 3 (EDGE=0, MASK=0x08) held high, reaching REQ, then dropped before ack -> ir_out=0 within 4 clocks, state=IDLE, PEND=0.
REQ-037 The bench SHALL cover: W1C write of PEND=0x01 in the same cycle a new edge sets PEND[0] -> PEND[0]=1 afterwards.
REQ-038 The bench SHALL cover: rst driven low asynchronously between clock edges while ir_out=1 -> ir_out=0 before the next edge, and MASK reads 0.
